// File: rtl/ddr3_app_pkg.sv
// Shared definitions for the DDR3 application-interface responder.
// Command encodings, address width and error-flag bit positions.
package ddr3_app_pkg;

    localparam int APP_ADDR_W = 27;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    localparam int ERR_ILLEGAL = 0;
    localparam int ERR_WDF_END = 1;
    localparam int ERR_CMD_OVF = 2;

    typedef enum logic [1:0] {
        EX_IDLE,
        EX_READ,
        EX_WRITE,
        EX_DROP
    } exec_e;

endpackage

// File: rtl/ddr3_sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty flags.
// DEPTH must be a power of two, at least 2.
module ddr3_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ddr3_app_responder.sv
// Target side of the DDR3 user application interface, backed by
// a word array; in-order command execution with fixed read latency.
module ddr3_app_responder
    import ddr3_app_pkg::*;
#(
    parameter int DATA_WIDTH   = 128,
    parameter int MEM_AW       = 10,
    parameter int CMD_DEPTH    = 4,
    parameter int WDF_DEPTH    = 4,
    parameter int RD_LATENCY   = 4,
    parameter int CALIB_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [APP_ADDR_W-1:0] app_addr,
    input  logic [2:0]            app_cmd,
    input  logic                  app_en,
    output logic                  app_rdy,
    input  logic [DATA_WIDTH-1:0] app_wdf_data,
    input  logic                  app_wdf_wren,
    input  logic                  app_wdf_end,
    output logic                  app_wdf_rdy,
    output logic [DATA_WIDTH-1:0] app_rd_data,
    output logic                  app_rd_data_valid,
    output logic                  app_rd_data_end,
    output logic                  init_calib_complete,
    output logic [2:0]            err_flags
);

    localparam int CW    = $clog2(CALIB_CYCLES + 1);
    localparam int CMD_W = 3 + MEM_AW;

    logic [CW-1:0]         calib_cnt;

    logic                  cmd_push;
    logic [CMD_W-1:0]      cmd_din;
    logic [CMD_W-1:0]      cmd_dout;
    logic                  cmd_full;
    logic                  cmd_empty;
    logic                  cmd_pop;

    logic                  wdf_push;
    logic [DATA_WIDTH-1:0] wdf_dout;
    logic                  wdf_full;
    logic                  wdf_empty;
    logic                  wdf_pop;

    logic [2:0]            head_cmd;
    logic [MEM_AW-1:0]     head_idx;
    exec_e                 exec;

    logic [DATA_WIDTH-1:0] mem [2**MEM_AW];
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  ram_v;
    logic [RD_LATENCY-1:0] pv;
    logic [DATA_WIDTH-1:0] pd [RD_LATENCY];

    // Column bits and aliasing bits of the address are dropped.
    logic unused_addr;
    assign unused_addr = ^{app_addr[2:0], app_addr[APP_ADDR_W-1:MEM_AW+3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            calib_cnt           <= '0;
            init_calib_complete <= 1'b0;
        end else begin
            if (calib_cnt != CW'(CALIB_CYCLES))
                calib_cnt <= calib_cnt + 1'b1;
            if (calib_cnt == CW'(CALIB_CYCLES - 1))
                init_calib_complete <= 1'b1;
        end
    end

    assign app_rdy     = init_calib_complete && !cmd_full;
    assign app_wdf_rdy = init_calib_complete && !wdf_full;

    assign cmd_push = app_en && app_rdy;
    assign cmd_din  = {app_cmd, app_addr[MEM_AW+2:3]};
    assign wdf_push = app_wdf_wren && app_wdf_rdy;

    ddr3_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_push),
        .din   (cmd_din),
        .pop   (cmd_pop),
        .dout  (cmd_dout),
        .full  (cmd_full),
        .empty (cmd_empty)
    );

    ddr3_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (WDF_DEPTH)
    ) u_wdf_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wdf_push),
        .din   (app_wdf_data),
        .pop   (wdf_pop),
        .dout  (wdf_dout),
        .full  (wdf_full),
        .empty (wdf_empty)
    );

    assign head_cmd = cmd_dout[CMD_W-1 -: 3];
    assign head_idx = cmd_dout[MEM_AW-1:0];

    // A write at the head blocks everything behind it until its data lands.
    always_comb begin
        exec = EX_IDLE;
        if (!cmd_empty) begin
            unique case (head_cmd)
                CMD_RD:  exec = EX_READ;
                CMD_WR:  exec = wdf_empty ? EX_IDLE : EX_WRITE;
                default: exec = EX_DROP;
            endcase
        end
    end

    assign cmd_pop = (exec != EX_IDLE);
    assign wdf_pop = (exec == EX_WRITE);

    always_ff @(posedge clk) begin
        if (exec == EX_WRITE) mem[head_idx] <= wdf_dout;
        if (exec == EX_READ)  ram_q <= mem[head_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_v <= 1'b0;
            pv    <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pd[i] <= '0;
        end else begin
            ram_v <= (exec == EX_READ);
            pv[0] <= ram_v;
            if (ram_v) pd[0] <= ram_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) pd[i] <= pd[i-1];
            end
        end
    end

    assign app_rd_data_valid = pv[RD_LATENCY-1];
    assign app_rd_data_end   = pv[RD_LATENCY-1];
    assign app_rd_data       = pd[RD_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flags <= '0;
        end else begin
            if (exec == EX_DROP)
                err_flags[ERR_ILLEGAL] <= 1'b1;
            if (app_wdf_wren != app_wdf_end)
                err_flags[ERR_WDF_END] <= 1'b1;
            if (app_en && init_calib_complete && cmd_full)
                err_flags[ERR_CMD_OVF] <= 1'b1;
        end
    end

endmodule
